regwb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file.
- Shares that port between two writers:
  - the in-order pipeline writeback stage, which has priority;
  - the long-latency unit (mul/div, uncached load return), through a valid/ready handshake and a small result FIFO.
- Keeps a per-register pending scoreboard for long-latency destinations, so decode can stall on RAW hazards and issue can block on WAW hazards.
- Sits between WB/long-latency unit and the regfile's write port (reg_write/waddr/wdata).

---
 rtl/regwb_arbiter_pkg.sv | 22 ++
 rtl/regwb_arbiter_sync_fifo.sv | 70 +++++++
 rtl/regwb_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_regwb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regwb_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_AW / REG_DW : register address / data widths
//   REG_ZERO        : hard-wired zero register, never written or tracked
//   arb_state_e     : arbiter FSM states
//   wr_req_t        : one register write request (address + data)
package regwb_arbiter_pkg;

  localparam int unsigned       REG_AW   = 5;
  localparam int unsigned       REG_DW   = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regwb_arbiter_sync_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port
// is free.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write an entry (ignored when full unless popping as well)
//   pop/dout : dout shows the head; pop removes it (ignored when empty)
//   full     : DEPTH entries held
//   empty    : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_count == CNT_MAX);
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rptr];

  // When full, a simultaneous pop frees the head slot, which is the slot
  // the write pointer already addresses.
  assign w_push = push & (~full | pop);
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regwb_arbiter.sv
// Owner of the register file's single write port. The in-order writeback
// stage has priority; long-latency results wait in a small FIFO and are
// force-drained after STARVE_LIMIT consecutive losses to writeback. A
// per-register pending scoreboard tracks long-latency destinations.
//   clk, rst          : clock, synchronous active-high reset
//   wb_valid/addr/data: writeback request; wb_stall = not accepted, hold
//   lu_valid/addr/data: long-latency result; lu_ready = FIFO can accept
//   iss_valid/addr    : long op issuing; iss_ready = issue permitted
//   chk_addr1/2       : decode sources; chk_busy1/2 = source pending
//   rf_we/waddr/wdata : registered write to the register file
module regwb_arbiter
  import regwb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_PEND     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [REG_DW-1:0] wb_data,
  output logic              wb_stall,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_AW-1:0] lu_addr,
  input  logic [REG_DW-1:0] lu_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_addr,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] chk_addr1,
  input  logic [REG_AW-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [REG_DW-1:0] rf_wdata
);

  localparam int unsigned NREGS = 1 << REG_AW;
  localparam int unsigned SCW   = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned PCW   = $clog2(MAX_PEND + 1);
  localparam logic [SCW-1:0] STARVE_ONE  = SCW'(1);
  localparam logic [SCW-1:0] STARVE_LAST = SCW'(STARVE_LIMIT - 1);
  localparam logic [PCW-1:0] PEND_ONE    = PCW'(1);
  localparam logic [PCW-1:0] PEND_MAX    = PCW'(MAX_PEND);

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic [SCW-1:0] r_starve;
  logic [SCW-1:0] w_starve_next;

  wr_req_t w_lu_req;
  wr_req_t w_fifo_head;
  logic    w_fifo_push;
  logic    w_fifo_pop;
  logic    w_fifo_full;
  logic    w_fifo_empty;

  wr_req_t w_gnt_req;
  logic    w_gnt_valid;
  logic    w_gnt_lu;
  logic    w_gnt_write;

  logic              r_rf_we;
  logic              r_we_lu;
  logic [REG_AW-1:0] r_rf_waddr;
  logic [REG_DW-1:0] r_rf_wdata;

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_next;
  logic [PCW-1:0]   r_pend_cnt;
  logic             w_iss_set;
  logic             w_sb_clr;

  // ---------------- long-latency result FIFO ----------------
  assign w_lu_req.addr = lu_addr;
  assign w_lu_req.data = lu_data;

  // A pop frees a slot this cycle, so a full FIFO still accepts then.
  assign lu_ready    = ~rst & (~w_fifo_full | w_fifo_pop);
  assign w_fifo_push = lu_valid & lu_ready;

  sync_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_fifo_push),
    .din   (w_lu_req),
    .pop   (w_fifo_pop),
    .dout  (w_fifo_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // ---------------- arbitration FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= NORMAL;
      r_starve <= '0;
    end else begin
      r_state  <= w_next_state;
      r_starve <= w_starve_next;
    end
  end

  // FORCE is entered on the cycle the counter becomes STARVE_LIMIT, so the
  // FIFO loses exactly STARVE_LIMIT times before the drain cycle.
  always_comb begin
    w_next_state  = r_state;
    w_starve_next = '0;
    unique case (r_state)
      NORMAL: begin
        if (wb_valid && !w_fifo_empty) begin
          w_starve_next = r_starve + STARVE_ONE;
          if (r_starve == STARVE_LAST) begin
            w_next_state = FORCE;
          end
        end
      end
      FORCE: begin
        w_next_state = NORMAL;
      end
    endcase
  end

  always_comb begin
    wb_stall    = 1'b0;
    w_fifo_pop  = 1'b0;
    w_gnt_valid = 1'b0;
    w_gnt_lu    = 1'b0;
    w_gnt_req   = '0;
    unique case (r_state)
      NORMAL: begin
        if (wb_valid) begin
          w_gnt_valid    = 1'b1;
          w_gnt_req.addr = wb_addr;
          w_gnt_req.data = wb_data;
        end else if (!w_fifo_empty) begin
          w_fifo_pop  = 1'b1;
          w_gnt_valid = 1'b1;
          w_gnt_lu    = 1'b1;
          w_gnt_req   = w_fifo_head;
        end
      end
      FORCE: begin
        if (!w_fifo_empty) begin
          wb_stall    = wb_valid;
          w_fifo_pop  = 1'b1;
          w_gnt_valid = 1'b1;
          w_gnt_lu    = 1'b1;
          w_gnt_req   = w_fifo_head;
        end else if (wb_valid) begin
          w_gnt_valid    = 1'b1;
          w_gnt_req.addr = wb_addr;
          w_gnt_req.data = wb_data;
        end
      end
    endcase
  end

  // ---------------- registered write port ----------------
  // Writes to the zero register are consumed without touching the port.
  assign w_gnt_write = w_gnt_valid & (w_gnt_req.addr != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we    <= 1'b0;
      r_we_lu    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_gnt_write;
      r_we_lu <= w_gnt_write & w_gnt_lu;
      if (w_gnt_write) begin
        r_rf_waddr <= w_gnt_req.addr;
        r_rf_wdata <= w_gnt_req.data;
      end
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;

  // ---------------- pending scoreboard ----------------
  assign iss_ready = ~rst & ((iss_addr == REG_ZERO) |
                             (~r_pending[iss_addr] & (r_pend_cnt < PEND_MAX)));
  assign w_iss_set = iss_valid & iss_ready & (iss_addr != REG_ZERO);
  // Clear as the regfile captures the long-latency write, so busy never
  // drops before the data is readable.
  assign w_sb_clr  = r_rf_we & r_we_lu;

  always_comb begin
    w_pending_next = r_pending;
    if (w_sb_clr) begin
      w_pending_next[r_rf_waddr] = 1'b0;
    end
    if (w_iss_set) begin
      w_pending_next[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pending <= w_pending_next;
      unique case ({w_iss_set, w_sb_clr})
        2'b10:   r_pend_cnt <= r_pend_cnt + PEND_ONE;
        2'b01:   r_pend_cnt <= r_pend_cnt - PEND_ONE;
        default: r_pend_cnt <= r_pend_cnt;
      endcase
    end
  end

  assign chk_busy1 = r_pending[chk_addr1];
  assign chk_busy2 = r_pending[chk_addr2];

endmodule

// File: tb/tb_regwb_arbiter.sv
module tb_regwb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regwb_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4),
    .MAX_PEND     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_stall  (wb_stall),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_addr   (lu_addr),
    .lu_data   (lu_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_busy1 (chk_busy1),
    .chk_busy2 (chk_busy2),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  // Protocol monitor: bench-side record of outstanding long-latency targets.
  logic [31:0] tb_pend;
  logic        p_stall;
  logic [4:0]  p_addr;
  logic [31:0] p_data;

  always @(posedge clk) begin
    if (rst) begin
      tb_pend <= '0;
      p_stall <= 1'b0;
    end else begin
      if (lu_valid && lu_ready) begin
        assert (tb_pend[lu_addr]) else $error("protocol: lu result to non-pending r%0d", lu_addr);
      end
      if (wb_valid && wb_addr != 5'd0) begin
        assert (!tb_pend[wb_addr]) else $error("protocol: wb write to pending r%0d", wb_addr);
      end
      if (p_stall) begin
        assert (wb_valid && wb_addr == p_addr && wb_data == p_data)
          else $error("protocol: wb changed while stalled");
      end
      if (rf_we) tb_pend[rf_waddr] <= 1'b0;
      if (iss_valid && iss_ready && iss_addr != 5'd0) tb_pend[iss_addr] <= 1'b1;
      p_stall <= wb_stall;
      p_addr  <= wb_addr;
      p_data  <= wb_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h33;
    iss_valid = 1'b1; iss_addr = 5'd3;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lu_ready got=%b exp=0", lu_ready); end
      n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL reset_iss_ready got=%b exp=0", iss_ready); end
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    end
    n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rf_bus got=%0d/%h exp=0/0", rf_waddr, rf_wdata);
    end
    for (int a = 0; a < 32; a++) begin
      chk_addr1 = 5'(a);
      #1;
      n_checks++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy r%0d got=%b exp=0", a, chk_busy1); end
    end
    lu_valid = 1'b0; iss_valid = 1'b0; iss_addr = 5'd0; chk_addr1 = 5'd0;
    rst = 1'b0;
    tick();
    n_checks++; if (lu_ready !== 1'b1 || iss_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_ready got lu=%b iss=%b exp=1/1", lu_ready, iss_ready);
    end
  endtask

  task automatic test_wb_only();
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    #1;
    n_checks++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL wb_stall got=%b exp=0", wb_stall); end
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      n_fail++; $display("FAIL wb_write got=%b/%0d/%h exp=1/5/1234", rf_we, rf_waddr, rf_wdata);
    end
    wb_addr = 5'd0; wb_data = 32'hFFFF;
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL wb_zero_addr got=%b exp=0", rf_we); end
    wb_valid = 1'b0;
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL wb_idle got=%b exp=0", rf_we); end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_addr = 5'd7; chk_addr1 = 5'd7; chk_addr2 = 5'd0;
    #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL sb_iss_ready got=%b exp=1", iss_ready); end
    n_checks++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_pre got=%b exp=0", chk_busy1); end
    tick();
    iss_valid = 1'b0; chk_addr2 = 5'd7;
    #1;
    n_checks++; if (chk_busy1 !== 1'b1 || chk_busy2 !== 1'b1) begin
      n_fail++; $display("FAIL sb_busy_set got=%b/%b exp=1/1", chk_busy1, chk_busy2);
    end
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL sb_reissue got=%b exp=0", iss_ready); end
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hDEAD;
    #1;
    n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL sb_lu_ready got=%b exp=1", lu_ready); end
    tick();
    lu_valid = 1'b0;
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEAD) begin
      n_fail++; $display("FAIL sb_lu_write got=%b/%0d/%h exp=1/7/dead", rf_we, rf_waddr, rf_wdata);
    end
    n_checks++; if (chk_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_hold got=%b exp=1", chk_busy1); end
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL sb_we_drop got=%b exp=0", rf_we); end
    n_checks++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_clear got=%b exp=0", chk_busy1); end
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL sb_iss_after got=%b exp=1", iss_ready); end
    iss_addr = 5'd0; chk_addr1 = 5'd0; chk_addr2 = 5'd0;
  endtask

  task automatic test_arbitration();
    logic        exp_stall [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    logic [4:0]  exp_addr  [11] = '{20, 20, 20, 20, 10, 20, 20, 20, 20, 11, 20};
    logic [31:0] exp_data  [11] = '{32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'hA0,
                                    32'h5555, 32'h5555, 32'h5555, 32'h5555, 32'hB0, 32'h5555};
    iss_valid = 1'b1; iss_addr = 5'd10; tick();
    iss_addr = 5'd11; tick();
    iss_valid = 1'b0; iss_addr = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd20; wb_data = 32'h5555;
    lu_valid = 1'b1; lu_addr = 5'd10; lu_data = 32'hA0;
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd20) begin
      n_fail++; $display("FAIL arb_first got=%b/%0d exp=1/20", rf_we, rf_waddr);
    end
    lu_addr = 5'd11; lu_data = 32'hB0;
    for (int c = 0; c < 11; c++) begin
      #1;
      n_checks++; if (wb_stall !== exp_stall[c]) begin
        n_fail++; $display("FAIL arb_stall[%0d] got=%b exp=%b", c, wb_stall, exp_stall[c]);
      end
      tick();
      if (c == 0) lu_valid = 1'b0;
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== exp_addr[c] || rf_wdata !== exp_data[c]) begin
        n_fail++; $display("FAIL arb_grant[%0d] got=%b/%0d/%h exp=1/%0d/%h",
                           c, rf_we, rf_waddr, rf_wdata, exp_addr[c], exp_data[c]);
      end
    end
    wb_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_fifo_full();
    iss_valid = 1'b1; iss_addr = 5'd12; tick();
    iss_addr = 5'd13; tick();
    iss_addr = 5'd14; tick();
    iss_valid = 1'b0; iss_addr = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd21; wb_data = 32'h2121;
    lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'hC12; tick();
    lu_addr = 5'd13; lu_data = 32'hC13; tick();
    lu_addr = 5'd14; lu_data = 32'hC14;
    #1;
    n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_lu_ready got=%b exp=0", lu_ready); end
    tick();
    tick();
    #1;
    n_checks++; if (lu_ready !== 1'b0 || wb_stall !== 1'b0) begin
      n_fail++; $display("FAIL full_hold got=%b/%b exp=0/0", lu_ready, wb_stall);
    end
    tick();
    #1;
    n_checks++; if (wb_stall !== 1'b1 || lu_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_force got stall=%b ready=%b exp=1/1", wb_stall, lu_ready);
    end
    tick();
    lu_valid = 1'b0;
    n_checks++; if (rf_we !== 1'b1 || rf_wdata !== 32'hC12) begin
      n_fail++; $display("FAIL full_pop1 got=%b/%h exp=1/c12", rf_we, rf_wdata);
    end
    #1;
    n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_still got=%b exp=0", lu_ready); end
    tick();
    n_checks++; if (rf_waddr !== 5'd21 || rf_wdata !== 32'h2121) begin
      n_fail++; $display("FAIL full_wb got=%0d/%h exp=21/2121", rf_waddr, rf_wdata);
    end
    wb_valid = 1'b0;
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== 32'hC13) begin
      n_fail++; $display("FAIL full_pop2 got=%b/%0d/%h exp=1/13/c13", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd14 || rf_wdata !== 32'hC14) begin
      n_fail++; $display("FAIL full_pop3 got=%b/%0d/%h exp=1/14/c14", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL full_drained got=%b exp=0", rf_we); end
    tick();
  endtask

  task automatic test_limits();
    iss_valid = 1'b1;
    for (int a = 1; a <= 4; a++) begin
      iss_addr = 5'(a);
      #1;
      n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL lim_issue r%0d got=%b exp=1", a, iss_ready); end
      tick();
    end
    iss_addr = 5'd9;
    #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL lim_max got=%b exp=0", iss_ready); end
    lu_valid = 1'b1; lu_addr = 5'd1; lu_data = 32'h11;
    tick();
    lu_valid = 1'b0;
    #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL lim_pop_cycle got=%b exp=0", iss_ready); end
    tick();
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1) begin
      n_fail++; $display("FAIL lim_write got=%b/%0d exp=1/1", rf_we, rf_waddr);
    end
    #1;
    n_checks++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL lim_we_cycle got=%b exp=0", iss_ready); end
    tick();
    #1;
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL lim_freed got=%b exp=1", iss_ready); end
    iss_valid = 1'b0; iss_addr = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd22; wb_data = 32'h2222;
    lu_valid = 1'b1; lu_addr = 5'd2; lu_data = 32'h22; tick();
    lu_addr = 5'd3; lu_data = 32'h33; tick();
    lu_valid = 1'b0; wb_valid = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (lu_ready !== 1'b0 || iss_ready !== 1'b0) begin
      n_fail++; $display("FAIL lim_rst_ready got=%b/%b exp=0/0", lu_ready, iss_ready);
    end
    tick();
    rst = 1'b0;
    n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_fail++; $display("FAIL lim_rst_rf got=%b/%0d/%h exp=0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    chk_addr1 = 5'd2; chk_addr2 = 5'd3;
    #1;
    n_checks++; if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin
      n_fail++; $display("FAIL lim_rst_busy got=%b/%b exp=0/0", chk_busy1, chk_busy2);
    end
    chk_addr1 = 5'd4; iss_addr = 5'd9;
    #1;
    n_checks++; if (chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL lim_rst_busy4 got=%b exp=0", chk_busy1); end
    n_checks++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL lim_rst_iss got=%b exp=1", iss_ready); end
    iss_addr = 5'd0; chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL lim_no_write[%0d] got=%b exp=0", c, rf_we); end
    end
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    iss_valid = 1'b0; iss_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
    test_reset();
    test_wb_only();
    test_scoreboard();
    test_arbitration();
    test_fifo_full();
    test_limits();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
